// File: rtl/flush_redirect_ctrl.sv
// Pipeline flush sequencer for WB-stage exceptions and ertn.
// Kills stage valids, discards responses to stale inst-RAM requests, then issues one redirect.
module flush_redirect_ctrl #(
  parameter int unsigned MAX_OUT      = 2,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic [31:0] ex_entry,
  input  logic [31:0] era,
  input  logic        fs_req_fire,
  input  logic        fs_resp_fire,
  output logic        req_block,
  output logic        fs_discard,
  output logic        flush_all,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam int unsigned FlW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FlW-1:0] FlLast = FlW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StFlush, StDrain, StRedirect} state_e;

  state_e           state_q, state_d;
  logic [2:0]       out_cnt_q, out_cnt_d;
  logic [2:0]       drop_cnt_q, drop_cnt_d;
  logic [2:0]       drop_dec;
  logic [FlW-1:0]   fl_cnt_q, fl_cnt_d;
  logic [31:0]      target_q, target_d;
  logic             trigger;
  logic             resp_ok;

  assign trigger    = (state_q == StIdle) & (wb_ex | ertn_flush);
  // A response with nothing outstanding is dropped rather than underflowing the counter.
  assign resp_ok    = fs_resp_fire & (out_cnt_q != 3'd0);
  assign out_cnt_d  = out_cnt_q + 3'(fs_req_fire) - 3'(resp_ok);
  assign fs_discard = fs_resp_fire & (drop_cnt_q != 3'd0) & (state_q != StIdle);
  assign drop_dec   = drop_cnt_q - 3'(fs_discard);
  assign req_block  = (out_cnt_q == 3'(MAX_OUT)) | (state_q != StIdle) | trigger;
  assign busy       = (state_q != StIdle);

  always_comb begin
    state_d        = state_q;
    drop_cnt_d     = drop_dec;
    fl_cnt_d       = fl_cnt_q;
    target_d       = target_q;
    flush_all      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          // Stale requests include one accepted in this very cycle.
          target_d   = wb_ex ? ex_entry : era;
          drop_cnt_d = out_cnt_d;
          fl_cnt_d   = '0;
          flush_all  = 1'b1;
          state_d    = StFlush;
        end
      end
      StFlush: begin
        flush_all = 1'b1;
        fl_cnt_d  = fl_cnt_q + FlW'(1);
        if (fl_cnt_q == FlLast) begin
          state_d = (drop_dec != 3'd0) ? StDrain : StRedirect;
        end
      end
      StDrain: begin
        flush_all = 1'b1;
        if (drop_dec == 3'd0) begin
          state_d = StRedirect;
        end
      end
      StRedirect: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      out_cnt_q  <= 3'd0;
      drop_cnt_q <= 3'd0;
      fl_cnt_q   <= '0;
      target_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
      target_q   <= target_d;
    end
  end

  resp_underflow_a : assert property (@(posedge clk) disable iff (!resetn)
    fs_resp_fire |-> (out_cnt_q != 3'd0));

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Directed bench for flush_redirect_ctrl; redirects are checked by a scoreboard monitor.
module tb_flush_redirect_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wb_ex = 1'b0;
  logic        ertn_flush = 1'b0;
  logic [31:0] ex_entry = 32'h0;
  logic [31:0] era = 32'h0;
  logic        fs_req_fire = 1'b0;
  logic        fs_resp_fire = 1'b0;
  logic        req_block;
  logic        fs_discard;
  logic        flush_all;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  flush_redirect_ctrl #(
    .MAX_OUT     (2),
    .FLUSH_CYCLES(1)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .wb_ex         (wb_ex),
    .ertn_flush    (ertn_flush),
    .ex_entry      (ex_entry),
    .era           (era),
    .fs_req_fire   (fs_req_fire),
    .fs_resp_fire  (fs_resp_fire),
    .req_block     (req_block),
    .fs_discard    (fs_discard),
    .flush_all     (flush_all),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input int at);
    exp_t e;
    e.pc  = pc;
    e.cyc = at;
    sb.push_back(e);
  endtask

  // Monitor: every redirect pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && redirect_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_redirect: got pc %h at cycle %0d, required no redirect",
                 redirect_pc, cyc);
      end else begin
        e = sb.pop_front();
        chk("redirect_pc", redirect_pc, e.pc);
        chk("redirect_cycle", cyc, e.cyc);
        chk("flush_all_in_redirect", flush_all, 0);
      end
    end
  end

  initial begin
    int t;
    // Reset state
    #3;
    chk("rst_req_block", req_block, 0);
    chk("rst_flush_all", flush_all, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_busy", busy, 0);
    step(); step();
    resetn = 1'b1;

    // 1: exception with nothing outstanding
    step();
    wb_ex = 1'b1; ex_entry = 32'h1C00_8000; t = cyc;
    push(32'h1C00_8000, t + 2);
    smp(); chk("t1_flush_T", flush_all, 1); chk("t1_block_T", req_block, 1);
    chk("t1_busy_T", busy, 0);
    step(); wb_ex = 1'b0; ex_entry = 32'hDEAD_BEEF;
    smp(); chk("t1_flush_T1", flush_all, 1); chk("t1_busy_T1", busy, 1);
    step();
    smp(); chk("t1_block_redir", req_block, 1);
    step();
    smp(); chk("t1_busy_T3", busy, 0); chk("t1_block_T3", req_block, 0);

    // 2: two outstanding requests, ertn
    step(); fs_req_fire = 1'b1;
    step();
    step(); fs_req_fire = 1'b0; ertn_flush = 1'b1; era = 32'h1C00_0100; t = cyc;
    push(32'h1C00_0100, t + 5);
    step(); ertn_flush = 1'b0;
    smp(); chk("t2_flush", flush_all, 1);
    step();
    smp(); chk("t2_drain_busy", busy, 1); chk("t2_drain_flush", flush_all, 1);
    step(); fs_resp_fire = 1'b1;
    smp(); chk("t2_discard1", fs_discard, 1);
    step();
    smp(); chk("t2_discard2", fs_discard, 1);
    step(); fs_resp_fire = 1'b0;
    step();
    smp(); chk("t2_busy_after", busy, 0); chk("t2_block_after", req_block, 0);

    // 3: both flags plus same-cycle request at out_cnt=1
    step(); fs_req_fire = 1'b1;
    step(); wb_ex = 1'b1; ertn_flush = 1'b1;
    ex_entry = 32'h1C00_A000; era = 32'h1C00_0200; t = cyc;
    push(32'h1C00_A000, t + 5);
    step(); fs_req_fire = 1'b0; wb_ex = 1'b0; ertn_flush = 1'b0;
    step();
    smp(); chk("t3_drain_busy", busy, 1); chk("t3_drain_block", req_block, 1);
    step(); fs_resp_fire = 1'b1;
    smp(); chk("t3_discard1", fs_discard, 1);
    step();
    smp(); chk("t3_discard2", fs_discard, 1);
    step(); fs_resp_fire = 1'b0;
    step();
    smp(); chk("t3_idle", busy, 0);

    // 4: outstanding-request limit
    step(); fs_req_fire = 1'b1;
    smp(); chk("t4_block_0", req_block, 0);
    step();
    smp(); chk("t4_block_1", req_block, 0);
    step(); fs_req_fire = 1'b0;
    smp(); chk("t4_block_full", req_block, 1);
    step(); fs_resp_fire = 1'b1;
    smp(); chk("t4_block_resp_cycle", req_block, 1); chk("t4_no_discard_idle", fs_discard, 0);
    step(); fs_resp_fire = 1'b0;
    smp(); chk("t4_block_after_resp", req_block, 0);
    step(); fs_req_fire = 1'b1; fs_resp_fire = 1'b1;
    step(); fs_req_fire = 1'b0; fs_resp_fire = 1'b0;
    smp(); chk("t4_simul_keeps", req_block, 0);
    step(); fs_req_fire = 1'b1;
    step(); fs_req_fire = 1'b0;
    smp(); chk("t4_simul_then_full", req_block, 1);
    step(); fs_resp_fire = 1'b1;
    step();
    step(); fs_resp_fire = 1'b0;

    // 5: reset during DRAIN aborts the sequence
    step(); fs_req_fire = 1'b1;
    step(); fs_req_fire = 1'b0; wb_ex = 1'b1; ex_entry = 32'h1C00_E000;
    step(); wb_ex = 1'b0;
    step();
    smp(); chk("t5_in_drain", busy, 1);
    step(); #2; resetn = 1'b0; #1;
    chk("t5_rst_block", req_block, 0);
    chk("t5_rst_discard", fs_discard, 0);
    chk("t5_rst_flush", flush_all, 0);
    chk("t5_rst_redirect", redirect_valid, 0);
    chk("t5_rst_pc", redirect_pc, 0);
    chk("t5_rst_busy", busy, 0);
    step(); step(); resetn = 1'b1;
    step(); step(); step(); step();
    step(); fs_req_fire = 1'b1;
    step();
    smp(); chk("t5_cnt_cleared_1", req_block, 0);
    step(); fs_req_fire = 1'b0;
    smp(); chk("t5_cnt_cleared_2", req_block, 1);
    step(); fs_resp_fire = 1'b1;
    step();
    step(); fs_resp_fire = 1'b0;

    // 6: second exception during FLUSH is ignored
    step(); wb_ex = 1'b1; ex_entry = 32'h1C00_C000; t = cyc;
    push(32'h1C00_C000, t + 2);
    step(); ex_entry = 32'h1C00_D000;
    step(); wb_ex = 1'b0;
    step(); step(); step(); step();
    smp(); chk("t6_idle", busy, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
